// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: default reset/exception addresses, the NOP
// encoding and the next-PC source, listed in ascending priority.
package fetch_stage_pkg;

  localparam logic [7:0]  DEF_RESET_PC   = 8'h00;
  localparam logic [7:0]  DEF_EXC_VECTOR = 8'h80;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_EXC,
    SEL_LOAD
  } pc_sel_e;

  // Every source other than sequential/hold discards the IF/ID instruction.
  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JUMP) ||
           (sel == SEL_EXC)    || (sel == SEL_LOAD);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: the system/ID-stage control inputs, the instruction-memory
// port and the IF/ID register outputs.
interface fetch_stage_if #(
  parameter int PC_WIDTH = 8
);
  logic                SYS_load;
  logic [PC_WIDTH-1:0] SYS_pc_val;
  logic                FETCH_stall;
  logic                FETCH_flush;
  logic                FETCH_branch_taken;
  logic [31:0]         FETCH_branch_offset;
  logic                FETCH_jump;
  logic [25:0]         FETCH_jump_index;
  logic                FETCH_exception;
  logic [PC_WIDTH-1:0] IMEM_PC;
  logic [31:0]         IMEM_instruction;
  logic [31:0]         FETCH_instr_out;
  logic [PC_WIDTH-1:0] FETCH_pc_out;
  logic [PC_WIDTH-1:0] FETCH_pc_plus4;
  logic                FETCH_valid;
  logic [PC_WIDTH-1:0] FETCH_epc;

  modport master (
    input  SYS_load, SYS_pc_val, FETCH_stall, FETCH_flush,
           FETCH_branch_taken, FETCH_branch_offset, FETCH_jump,
           FETCH_jump_index, FETCH_exception, IMEM_instruction,
    output IMEM_PC, FETCH_instr_out, FETCH_pc_out, FETCH_pc_plus4,
           FETCH_valid, FETCH_epc
  );

  modport slave (
    output SYS_load, SYS_pc_val, FETCH_stall, FETCH_flush,
           FETCH_branch_taken, FETCH_branch_offset, FETCH_jump,
           FETCH_jump_index, FETCH_exception, IMEM_instruction,
    input  IMEM_PC, FETCH_instr_out, FETCH_pc_out, FETCH_pc_plus4,
           FETCH_valid, FETCH_epc
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: sequential adder, branch shift-add, jump
// concatenation, exception vector and external load, in priority order.
module fetch_next_pc
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                valid,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] pc_val,
  input  logic                exception,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                branch_taken,
  input  logic [31:0]         branch_offset,
  input  logic                stall,
  output pc_sel_e             sel,
  output logic [PC_WIDTH-1:0] next_pc
);

  // ID-stage redirects only count while IF/ID holds a live instruction.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc + PC_WIDTH'(4);
    if (load) begin
      sel     = SEL_LOAD;
      next_pc = pc_val & ~PC_WIDTH'(3);
    end else if (valid && exception) begin
      sel     = SEL_EXC;
      next_pc = EXC_VECTOR;
    end else if (valid && jump) begin
      sel     = SEL_JUMP;
      next_pc = PC_WIDTH'({jump_index, 2'b00});
    end else if (valid && branch_taken) begin
      sel     = SEL_BRANCH;
      next_pc = pc_plus4 + PC_WIDTH'(branch_offset << 2);
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID pipeline register with
// valid/stall/flush, and exception PC capture.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset,
  fetch_stage_if.master bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_out_q;
  logic [PC_WIDTH-1:0] pc_plus4_q;
  logic [PC_WIDTH-1:0] epc_q;
  logic [31:0]         instr_q;
  logic                valid_q;
  pc_sel_e             sel;
  logic [PC_WIDTH-1:0] next_pc;
  logic                ifid_clear;
  logic                ifid_fill;

  fetch_next_pc #(
    .PC_WIDTH   (PC_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .pc            (pc_q),
    .pc_plus4      (pc_plus4_q),
    .valid         (valid_q),
    .load          (bus.SYS_load),
    .pc_val        (bus.SYS_pc_val),
    .exception     (bus.FETCH_exception),
    .jump          (bus.FETCH_jump),
    .jump_index    (bus.FETCH_jump_index),
    .branch_taken  (bus.FETCH_branch_taken),
    .branch_offset (bus.FETCH_branch_offset),
    .stall         (bus.FETCH_stall),
    .sel           (sel),
    .next_pc       (next_pc)
  );

  // Flush invalidates IF/ID whether or not the PC advances; a stall without
  // flush leaves IF/ID untouched.
  always_comb begin
    ifid_clear = is_redirect(sel) || bus.FETCH_flush;
    ifid_fill  = (sel == SEL_SEQ) && !bus.FETCH_flush;
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      epc_q      <= '0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      if (sel != SEL_HOLD) pc_q <= next_pc;
      if (sel == SEL_EXC) epc_q <= pc_out_q;
      if (ifid_clear) begin
        instr_q    <= NOP_INSTR;
        pc_out_q   <= '0;
        pc_plus4_q <= '0;
        valid_q    <= 1'b0;
      end else if (ifid_fill) begin
        instr_q    <= bus.IMEM_instruction;
        pc_out_q   <= pc_q;
        pc_plus4_q <= next_pc;
        valid_q    <= 1'b1;
      end
    end
  end

  assign bus.IMEM_PC         = pc_q;
  assign bus.FETCH_instr_out = instr_q;
  assign bus.FETCH_pc_out    = pc_out_q;
  assign bus.FETCH_pc_plus4  = pc_plus4_q;
  assign bus.FETCH_valid     = valid_q;
  assign bus.FETCH_epc       = epc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes the expected state
// for every clock edge into a queue, popped and compared after the edge.
module tb_fetch_stage;

  logic SYS_clk;
  logic SYS_reset;

  fetch_stage_if #(.PC_WIDTH(8)) bus ();

  fetch_stage #(
    .PC_WIDTH   (8),
    .RESET_PC   (8'h00),
    .EXC_VECTOR (8'h80)
  ) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0]  pc;
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  pc_out;
    logic [7:0]  plus4;
    logic [7:0]  epc;
  } state_t;

  state_t m;
  state_t exp_q[$];
  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  function automatic logic [31:0] imem_word(input logic [7:0] a);
    return {16'h2408, 8'h00, a};
  endfunction

  assign bus.IMEM_instruction = imem_word(bus.IMEM_PC);

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic state_t reset_state();
    state_t s;
    s.pc = 8'h00; s.valid = 1'b0; s.instr = 32'h0;
    s.pc_out = 8'h00; s.plus4 = 8'h00; s.epc = 8'h00;
    return s;
  endfunction

  function automatic state_t bubble(input state_t s);
    state_t r = s;
    r.valid = 1'b0; r.instr = 32'h0; r.pc_out = 8'h00; r.plus4 = 8'h00;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_state(input string tag, input state_t e);
    check({tag, ".IMEM_PC"}, {24'h0, bus.IMEM_PC}, {24'h0, e.pc});
    check({tag, ".valid"}, {31'h0, bus.FETCH_valid}, {31'h0, e.valid});
    check({tag, ".instr"}, bus.FETCH_instr_out, e.instr);
    check({tag, ".pc_out"}, {24'h0, bus.FETCH_pc_out}, {24'h0, e.pc_out});
    check({tag, ".pc_plus4"}, {24'h0, bus.FETCH_pc_plus4}, {24'h0, e.plus4});
    check({tag, ".epc"}, {24'h0, bus.FETCH_epc}, {24'h0, e.epc});
  endtask

  task automatic idle();
    bus.SYS_load = 1'b0;            bus.SYS_pc_val = 8'h00;
    bus.FETCH_stall = 1'b0;         bus.FETCH_flush = 1'b0;
    bus.FETCH_branch_taken = 1'b0;  bus.FETCH_branch_offset = 32'h0;
    bus.FETCH_jump = 1'b0;          bus.FETCH_jump_index = 26'h0;
    bus.FETCH_exception = 1'b0;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick(input string tag);
    state_t n = m;
    logic [27:0] jt;
    logic [31:0] bo;
    if (bus.SYS_load) begin
      n = bubble(m);
      n.pc = bus.SYS_pc_val & 8'hFC;
    end else if (m.valid && bus.FETCH_exception) begin
      n = bubble(m);
      n.pc = 8'h80;
      n.epc = m.pc_out;
    end else if (m.valid && bus.FETCH_jump) begin
      n = bubble(m);
      jt = {bus.FETCH_jump_index, 2'b00};
      n.pc = jt[7:0];
    end else if (m.valid && bus.FETCH_branch_taken) begin
      n = bubble(m);
      bo = bus.FETCH_branch_offset * 4;
      n.pc = m.plus4 + bo[7:0];
    end else if (bus.FETCH_stall) begin
      if (bus.FETCH_flush) n = bubble(m);
    end else if (bus.FETCH_flush) begin
      n = bubble(m);
      n.pc = m.pc + 8'd4;
    end else begin
      n.instr = imem_word(m.pc);
      n.pc_out = m.pc;
      n.plus4 = m.pc + 8'd4;
      n.valid = 1'b1;
      n.pc = m.pc + 8'd4;
    end
    m = n;
    exp_q.push_back(n);
    @(posedge SYS_clk);
    #1;
    compare_state(tag, exp_q.pop_front());
  endtask

  initial begin
    SYS_reset = 1'b0;
    idle();
    m = reset_state();
    repeat (2) @(posedge SYS_clk);
    #1;
    compare_state("reset", m);
    @(negedge SYS_clk);
    SYS_reset = 1'b1;
    check("seq_pc0", {24'h0, bus.IMEM_PC}, 32'h00);

    tick("seq1");
    check("seq_pc1", {24'h0, bus.IMEM_PC}, 32'h04);
    check("first_valid", {31'h0, bus.FETCH_valid}, 32'h1);
    tick("seq2");
    tick("seq3");
    tick("seq4");
    check("pc_out_lag", {24'h0, bus.FETCH_pc_out}, 32'h0C);
    check("plus4_pre_br", {24'h0, bus.FETCH_pc_plus4}, 32'h10);

    bus.FETCH_branch_taken = 1'b1;
    bus.FETCH_branch_offset = 32'hFFFF_FFFE;
    tick("branch");
    idle();
    check("branch_target", {24'h0, bus.IMEM_PC}, 32'h08);
    check("branch_bubble", {31'h0, bus.FETCH_valid}, 32'h0);
    tick("branch_fill");
    check("branch_ifid", {24'h0, bus.FETCH_pc_out}, 32'h08);

    bus.FETCH_stall = 1'b1;
    bus.FETCH_jump = 1'b1;
    bus.FETCH_jump_index = 26'h20;
    tick("jump_stall");
    idle();
    check("jump_target", {24'h0, bus.IMEM_PC}, 32'h80);
    tick("jump_fill");

    bus.SYS_load = 1'b1;
    bus.SYS_pc_val = 8'h13;
    tick("load13");
    idle();
    check("load_align", {24'h0, bus.IMEM_PC}, 32'h10);

    bus.SYS_load = 1'b1;
    bus.SYS_pc_val = 8'h22;
    tick("load22");
    idle();
    tick("to_24a");
    tick("to_24b");
    check("pc_out_24", {24'h0, bus.FETCH_pc_out}, 32'h24);

    bus.FETCH_exception = 1'b1;
    bus.FETCH_branch_taken = 1'b1;
    bus.FETCH_branch_offset = 32'h4;
    tick("exc_br");
    idle();
    check("exc_vector", {24'h0, bus.IMEM_PC}, 32'h80);
    check("exc_epc", {24'h0, bus.FETCH_epc}, 32'h24);

    bus.FETCH_exception = 1'b1;
    bus.FETCH_jump = 1'b1;
    bus.FETCH_jump_index = 26'h3F;
    tick("redir_ignored");
    idle();
    check("ignored_pc", {24'h0, bus.IMEM_PC}, 32'h84);
    check("ignored_epc", {24'h0, bus.FETCH_epc}, 32'h24);

    bus.SYS_load = 1'b1;
    bus.SYS_pc_val = 8'hFC;
    tick("load_fc");
    idle();
    tick("wrap");
    check("wrap_pc", {24'h0, bus.IMEM_PC}, 32'h00);
    check("wrap_plus4", {24'h0, bus.FETCH_pc_plus4}, 32'h00);

    bus.FETCH_flush = 1'b1;
    tick("flush_only");
    idle();
    check("flush_pc", {24'h0, bus.IMEM_PC}, 32'h04);
    tick("refill");

    bus.FETCH_stall = 1'b1;
    tick("stall1");
    tick("stall2");
    tick("stall3");
    check("stall_pc", {24'h0, bus.IMEM_PC}, 32'h08);
    check("stall_pc_out", {24'h0, bus.FETCH_pc_out}, 32'h04);
    bus.FETCH_flush = 1'b1;
    tick("stall_flush");
    bus.FETCH_flush = 1'b0;
    check("stall_flush_pc", {24'h0, bus.IMEM_PC}, 32'h08);

    #3;
    SYS_reset = 1'b0;
    #1;
    m = reset_state();
    compare_state("async_reset", m);
    @(negedge SYS_clk);
    SYS_reset = 1'b1;
    bus.FETCH_stall = 1'b0;
    tick("post_reset");
    check("post_reset_instr", bus.FETCH_instr_out, 32'h2408_0000);

    check("sb_drain", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
